// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop synchroniser, mid-bit sampling, valid/ack holding register,
// one-cycle framing-error pulse and sticky overrun flag.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset_n,
  input  logic                 RXD,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic s1, rxs, good, bad;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    idx_n = idx;
    sh_n = sh;
    good = 1'b0;
    bad = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = START;
      end
      START: if (cnt == MID) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rxs ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n = '0;
        sh_n = {rxs, sh[DATA_BITS-1:1]};
        idx_n = idx == IDX_LAST ? '0 : idx + IW'(1);
        if (idx == IDX_LAST) state_n = STOP;
      end
      STOP: if (cnt == LAST) begin
        cnt_n = '0;
        good = rxs;
        bad = !rxs;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b1;
      rxs <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      s1 <= RXD;
      rxs <= s1;
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      frame_err <= bad;
      // a completing byte beats a same-cycle ack, which then cannot cause an overrun
      if (good) begin
        rx_data <= sh;
        rx_valid <= 1'b1;
        overrun <= overrun | (rx_valid & ~rx_ack);
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver paired with the UART transmit path.
- Consumes an 8N1 line such as the transmitter's TXD, looped back or external, and recovers bytes.
- Presents each byte in a holding register with a valid/ack handshake to a downstream controller or checker.
- Reports framing and overrun errors.
- Runs on the 100 MHz system clock at the same baud count as the transmitter.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit (100e6/115200).
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- CLK100MHZ  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- RXD  input  1  serial line, idle high; asynchronous to CLK100MHZ.
- rx_ack  input  1  one-cycle pulse from the consumer; clears rx_valid.
- rx_data  output  DATA_BITS  last good received byte.
- rx_valid  output  1  high while rx_data holds an unread byte.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- overrun  output  1  sticky; set when a good byte completes while rx_valid=1; cleared only by reset.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset, while reset_n=0: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, both synchroniser flops=1, counters=0.
- Reset is asynchronous and takes effect mid-frame. The partial frame is discarded, and nothing is emitted after release until a fresh falling edge is seen.
- Synchroniser: RXD passes through 2 flops giving rxs. All decisions use rxs only.
- Counters:
  - Baud counter width is clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT-1.
  - HALF = CLKS_PER_BIT/2 (integer divide) = 434.
  - The bit index counts 0..DATA_BITS-1.
- IDLE: busy=0. When rxs=0, go to START with the baud counter cleared.
- START:
  - Count to HALF-1, then sample rxs.
  - If rxs=0, the start bit is valid: go to DATA, clear the counter and bit index.
  - If rxs=1, it was a glitch: return to IDLE with no flag.
- DATA:
  - Sample rxs when the counter reaches CLKS_PER_BIT-1, i.e. at mid-bit.
  - Shift the sample into the shift register MSB, shifting right, so the first bit lands at bit 0 after DATA_BITS shifts.
  - After bit index DATA_BITS-1, go to STOP.
- STOP: sample rxs at counter CLKS_PER_BIT-1.
  - If rxs=1, the byte is good:
    - rx_data <= shift register.
    - rx_valid <= 1.
    - If rx_valid was already 1 and rx_ack is not asserted this cycle, overrun <= 1. The new byte still overwrites rx_data.
  - If rxs=0, assert frame_err for one cycle and leave rx_data/rx_valid unchanged.
  - In either case go to IDLE the next cycle. Returning at mid-stop permits back-to-back frames with a single stop bit.
- Handshake:
  - rx_ack while rx_valid=1 clears rx_valid on the next edge.
  - rx_ack while rx_valid=0 is ignored.
  - If a good byte and rx_ack land in the same cycle, the new byte wins: rx_valid stays 1, rx_data is updated, no overrun.
- Latency: rx_valid rises 2 + HALF + DATA_BITS*CLKS_PER_BIT + CLKS_PER_BIT + 1 cycles after the RXD falling edge, within ±2 cycles. With defaults that is ≈8249 cycles.
- Line held low (break): start is valid, data samples 0x00, stop samples 0 → frame_err pulse. The block then returns to IDLE and immediately re-enters START while rxs=0. It must not emit any byte.

Test Plan:
- Reset mid-frame: drive 0xA1 at 868 clk/bit, pulse reset_n low during bit 4, then send 0xB2 → only 0xB2 is received; no frame_err.
- Single byte: send 0xA1 (start, bits 1,0,0,0,0,1,0,1, stop) → rx_valid rises ≈8249 cycles after the start edge; rx_data=8'hA1; frame_err=0; overrun=0.
- Back-to-back with ack: send 0xB2, 0xC3, 0xD4 with no idle gap, pulsing rx_ack 10 cycles after each rx_valid → three valid bytes in order; overrun stays 0.
- Overrun: send 0xA1 then 0xB2 with no rx_ack → rx_data=8'hB2, rx_valid=1, overrun=1 and sticky after a later rx_ack.
- Framing error: send 0xC3 with the stop bit driven low → frame_err pulses exactly one cycle; rx_valid remains 0; the next normal 0xD4 is received cleanly.
- Glitch rejection: drive RXD low for 200 cycles (<434), then high → busy pulses, returns to IDLE; no rx_valid, no frame_err. Also: hold RXD low for 20 bit times → at least one frame_err, no rx_valid.
